// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
//
// Execute-stage partner of the fetch-stage bimodal predictor. Each fetch-time
// prediction (taken bit and predicted target) travels with its PC through the
// F->D and D->E pipeline registers. In E the prediction is compared with the
// real branch outcome. On a mispredict the block redirects fetch and requests
// flushes of D and E. Every branch that reaches E also produces a registered
// training update for the predictor's saturating-counter table.
//
// Parameters:
//   IDX_W        predictor table index width; index = PC[IDX_W+1:2]
//   CNT_W        performance counter width (only with BRU_PERF_CNT_EN)
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous reset, active low
//   BPF          fetch-stage prediction (1 = taken)
//   BPTargetF    fetch-stage predicted target
//   PCF          fetch PC
//   StallD       hold the D register (a bubble goes into E)
//   FlushD       external flush of D
//   FlushE       external flush of E
//   BranchE      instruction in E is a conditional branch
//   TakenE       actual branch outcome in E
//   PCTargetE    computed branch target in E
//   PCPlus4E     fall-through PC in E
//   Redirect     mispredict resolved in E this cycle
//   RedirectPC   correct next PC while Redirect=1
//   FlushReqD    flush request for D (same as Redirect)
//   FlushReqE    flush request for E (same as Redirect)
//   UpdValid     predictor training strobe, one cycle after E
//   UpdIdx       predictor table index to train
//   UpdTaken     outcome to train with
//   BranchCnt    resolved-branch count, saturating (BRU_PERF_CNT_EN only)
//   MissCnt      mispredict count, saturating (BRU_PERF_CNT_EN only)
//
// Optional feature macro: BRU_PERF_CNT_EN adds the two performance counters.
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int IDX_W = 6
`ifdef BRU_PERF_CNT_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             BPF,
  input  logic [31:0]      BPTargetF,
  input  logic [31:0]      PCF,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic             FlushE,
  input  logic             BranchE,
  input  logic             TakenE,
  input  logic [31:0]      PCTargetE,
  input  logic [31:0]      PCPlus4E,
  output logic             Redirect,
  output logic [31:0]      RedirectPC,
  output logic             FlushReqD,
  output logic             FlushReqE,
  output logic             UpdValid,
  output logic [IDX_W-1:0] UpdIdx,
  output logic             UpdTaken
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] BranchCnt,
  output logic [CNT_W-1:0] MissCnt
`endif
);

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } bru_state_t;

  bru_state_t state;
  bru_state_t stateNext;

  logic        vldD;
  logic        bpD;
  logic [31:0] tgtD;
  logic [31:0] pcD;

  logic        vldE;
  logic        bpE;
  logic [31:0] tgtE;
  logic [31:0] pcE;

  // Only the index bits of the PC in E are needed for training; the rest of
  // the PC rides along so the pipeline registers carry the full instruction.
  logic unusedPcBits;
  assign unusedPcBits = ^{pcE[31:IDX_W+2], pcE[1:0]};

  // F->D register. A flush (external or from a mispredict) clears the slot and
  // takes priority over a stall; otherwise a stall holds the current contents.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vldD <= 1'b0;
      bpD  <= 1'b0;
      tgtD <= 32'h0;
      pcD  <= 32'h0;
    end else if (FlushD || Redirect) begin
      vldD <= 1'b0;
      bpD  <= 1'b0;
      tgtD <= 32'h0;
      pcD  <= 32'h0;
    end else if (!StallD) begin
      vldD <= 1'b1;
      bpD  <= BPF;
      tgtD <= BPTargetF;
      pcD  <= PCF;
    end
  end

  // D->E register. While D is stalled its instruction must not also advance,
  // so E receives a bubble; flushes and mispredicts also leave E empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vldE <= 1'b0;
      bpE  <= 1'b0;
      tgtE <= 32'h0;
      pcE  <= 32'h0;
    end else if (FlushE || Redirect || StallD) begin
      vldE <= 1'b0;
      bpE  <= 1'b0;
      tgtE <= 32'h0;
      pcE  <= 32'h0;
    end else begin
      vldE <= vldD;
      bpE  <= bpD;
      tgtE <= tgtD;
      pcE  <= pcD;
    end
  end

  // Mispredict detection. Direction errors and wrong targets on correctly
  // predicted taken branches all redirect. Resolution is suppressed in
  // RECOVER so a wrong-path slot can never trigger a second redirect. An
  // external FlushE in the same cycle does not stop resolution because it only
  // empties E at the next edge.
  always_comb begin
    Redirect   = 1'b0;
    RedirectPC = PCPlus4E;
    if (vldE && BranchE && (state == IDLE)) begin
      if (bpE && !TakenE) begin
        Redirect   = 1'b1;
        RedirectPC = PCPlus4E;
      end else if (!bpE && TakenE) begin
        Redirect   = 1'b1;
        RedirectPC = PCTargetE;
      end else if (bpE && TakenE && (tgtE != PCTargetE)) begin
        Redirect   = 1'b1;
        RedirectPC = PCTargetE;
      end
    end
  end

  assign FlushReqD = Redirect;
  assign FlushReqE = Redirect;

  // Recovery FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Recovery FSM next state: one RECOVER cycle after every redirect.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (Redirect) begin
          stateNext = RECOVER;
        end
      end
      RECOVER: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Training update, registered one cycle after E. Every valid branch trains
  // the table, mispredicted or not, including during RECOVER. Index and
  // outcome hold their last value between strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      UpdValid <= 1'b0;
      UpdIdx   <= '0;
      UpdTaken <= 1'b0;
    end else begin
      UpdValid <= vldE && BranchE;
      if (vldE && BranchE) begin
        UpdIdx   <= pcE[IDX_W+1:2];
        UpdTaken <= TakenE;
      end
    end
  end

`ifdef BRU_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating performance counters: branches count on each training strobe,
  // misses on each redirect. Both stop at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      BranchCnt <= '0;
      MissCnt   <= '0;
    end else begin
      if (UpdValid && (BranchCnt != {CNT_W{1'b1}})) begin
        BranchCnt <= BranchCnt + CntOne;
      end
      if (Redirect && (MissCnt != {CNT_W{1'b1}})) begin
        MissCnt <= MissCnt + CntOne;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Directed scenarios for reset, correct and incorrect predictions, stalls and
// reset during recovery, followed by a randomized run compared against a
// slot-based reference model of the fetch/decode/execute pipeline.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam int IDX_W = 6;

  logic             clk;
  logic             reset;
  logic             BPF;
  logic [31:0]      BPTargetF;
  logic [31:0]      PCF;
  logic             StallD;
  logic             FlushD;
  logic             FlushE;
  logic             BranchE;
  logic             TakenE;
  logic [31:0]      PCTargetE;
  logic [31:0]      PCPlus4E;
  logic             Redirect;
  logic [31:0]      RedirectPC;
  logic             FlushReqD;
  logic             FlushReqE;
  logic             UpdValid;
  logic [IDX_W-1:0] UpdIdx;
  logic             UpdTaken;
`ifdef BRU_PERF_CNT_EN
  logic [31:0]      BranchCnt;
  logic [31:0]      MissCnt;
`endif

  int errors = 0;
  int checks = 0;

  branch_resolve_unit #(.IDX_W(IDX_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .BPF       (BPF),
    .BPTargetF (BPTargetF),
    .PCF       (PCF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .FlushE    (FlushE),
    .BranchE   (BranchE),
    .TakenE    (TakenE),
    .PCTargetE (PCTargetE),
    .PCPlus4E  (PCPlus4E),
    .Redirect  (Redirect),
    .RedirectPC(RedirectPC),
    .FlushReqD (FlushReqD),
    .FlushReqE (FlushReqE),
    .UpdValid  (UpdValid),
    .UpdIdx    (UpdIdx),
    .UpdTaken  (UpdTaken)
`ifdef BRU_PERF_CNT_EN
    ,
    .BranchCnt (BranchCnt),
    .MissCnt   (MissCnt)
`endif
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drives every input for one cycle; called just after a rising edge.
  task automatic applyStimulus(input logic bpf, input logic [31:0] tgtf,
                               input logic [31:0] pcf, input logic stall,
                               input logic fd, input logic fe, input logic br,
                               input logic tk, input logic [31:0] ptgt,
                               input logic [31:0] pp4);
    BPF       = bpf;
    BPTargetF = tgtf;
    PCF       = pcf;
    StallD    = stall;
    FlushD    = fd;
    FlushE    = fe;
    BranchE   = br;
    TakenE    = tk;
    PCTargetE = ptgt;
    PCPlus4E  = pp4;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Reset for two edges while a resolvable branch is presented in E.
  task automatic test_reset();
    reset = 1'b0;
    applyStimulus(1'b1, 32'h40, 32'h10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h40, 32'h14);
    nextCycle();
    nextCycle();
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h99, 32'h24);
    @(negedge clk);
    checks++; if (Redirect !== 1'b0) begin errors++; $display("[TB] FAIL reset_redirect got=%0b exp=0", Redirect); end
    checks++; if (FlushReqD !== 1'b0) begin errors++; $display("[TB] FAIL reset_flushd got=%0b exp=0", FlushReqD); end
    checks++; if (FlushReqE !== 1'b0) begin errors++; $display("[TB] FAIL reset_flushe got=%0b exp=0", FlushReqE); end
    checks++; if (UpdValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_updvalid got=%0b exp=0", UpdValid); end
    checks++; if (UpdIdx !== 6'h00) begin errors++; $display("[TB] FAIL reset_updidx got=%0h exp=0", UpdIdx); end
    checks++; if (UpdTaken !== 1'b0) begin errors++; $display("[TB] FAIL reset_updtaken got=%0b exp=0", UpdTaken); end
    nextCycle();
  endtask

  // Not-taken prediction that was right: no redirect, then a training update.
  task automatic test_correct_not_taken();
    applyStimulus(1'b0, 32'h0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h600, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h604, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h180, 32'h104);
    @(negedge clk);
    checks++; if (Redirect !== 1'b0) begin errors++; $display("[TB] FAIL cnt_redirect got=%0b exp=0", Redirect); end
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h608, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (UpdValid !== 1'b1) begin errors++; $display("[TB] FAIL cnt_updvalid got=%0b exp=1", UpdValid); end
    checks++; if (UpdIdx !== 6'h00) begin errors++; $display("[TB] FAIL cnt_updidx got=%0h exp=0", UpdIdx); end
    checks++; if (UpdTaken !== 1'b0) begin errors++; $display("[TB] FAIL cnt_updtaken got=%0b exp=0", UpdTaken); end
    nextCycle();
  endtask

  // Taken branch predicted not-taken: one-cycle redirect to the target.
  task automatic test_mispredict_taken();
    applyStimulus(1'b0, 32'h0, 32'h104, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h504, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h140, 32'h108);
    @(negedge clk);
    checks++; if (Redirect !== 1'b1) begin errors++; $display("[TB] FAIL mt_redirect got=%0b exp=1", Redirect); end
    checks++; if (RedirectPC !== 32'h140) begin errors++; $display("[TB] FAIL mt_redirectpc got=%0h exp=140", RedirectPC); end
    checks++; if (FlushReqD !== 1'b1) begin errors++; $display("[TB] FAIL mt_flushd got=%0b exp=1", FlushReqD); end
    checks++; if (FlushReqE !== 1'b1) begin errors++; $display("[TB] FAIL mt_flushe got=%0b exp=1", FlushReqE); end
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h140, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h999, 32'h508);
    @(negedge clk);
    checks++; if (Redirect !== 1'b0) begin errors++; $display("[TB] FAIL mt_redirect_once got=%0b exp=0", Redirect); end
    checks++; if (FlushReqD !== 1'b0) begin errors++; $display("[TB] FAIL mt_flushd_once got=%0b exp=0", FlushReqD); end
    checks++; if (FlushReqE !== 1'b0) begin errors++; $display("[TB] FAIL mt_flushe_once got=%0b exp=0", FlushReqE); end
    checks++; if (UpdValid !== 1'b1) begin errors++; $display("[TB] FAIL mt_updvalid got=%0b exp=1", UpdValid); end
    checks++; if (UpdIdx !== 6'h01) begin errors++; $display("[TB] FAIL mt_updidx got=%0h exp=1", UpdIdx); end
    checks++; if (UpdTaken !== 1'b1) begin errors++; $display("[TB] FAIL mt_updtaken got=%0b exp=1", UpdTaken); end
    nextCycle();
  endtask

  // Not-taken branch predicted taken: redirect to fall-through, then RECOVER.
  task automatic test_mispredict_not_taken();
    applyStimulus(1'b1, 32'h2F0, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 32'h3F0, 32'h2F0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h2F4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h2F0, 32'h204);
    @(negedge clk);
    checks++; if (Redirect !== 1'b1) begin errors++; $display("[TB] FAIL mnt_redirect got=%0b exp=1", Redirect); end
    checks++; if (RedirectPC !== 32'h204) begin errors++; $display("[TB] FAIL mnt_redirectpc got=%0h exp=204", RedirectPC); end
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h204, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h777, 32'h2F8);
    @(negedge clk);
    checks++; if (Redirect !== 1'b0) begin errors++; $display("[TB] FAIL mnt_recover_redirect got=%0b exp=0", Redirect); end
    checks++; if (UpdValid !== 1'b1) begin errors++; $display("[TB] FAIL mnt_updvalid got=%0b exp=1", UpdValid); end
    checks++; if (UpdTaken !== 1'b0) begin errors++; $display("[TB] FAIL mnt_updtaken got=%0b exp=0", UpdTaken); end
    nextCycle();
  endtask

  // Two stall cycles with a taken prediction in D: bubbles reach E, then the
  // held prediction arrives intact (its target matches, so no redirect).
  task automatic test_stall();
    applyStimulus(1'b1, 32'h3A0, 32'h3C4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h3A0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h3A0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3A0, 32'h3C8);
    @(negedge clk);
    checks++; if (Redirect !== 1'b0) begin errors++; $display("[TB] FAIL stall_bubble_redirect got=%0b exp=0", Redirect); end
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h3A0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3A0, 32'h3C8);
    @(negedge clk);
    checks++; if (Redirect !== 1'b0) begin errors++; $display("[TB] FAIL stall_bubble2_redirect got=%0b exp=0", Redirect); end
    checks++; if (UpdValid !== 1'b0) begin errors++; $display("[TB] FAIL stall_bubble_upd got=%0b exp=0", UpdValid); end
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h3A4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3A0, 32'h3C8);
    @(negedge clk);
    checks++; if (Redirect !== 1'b0) begin errors++; $display("[TB] FAIL stall_release_redirect got=%0b exp=0", Redirect); end
    checks++; if (UpdValid !== 1'b0) begin errors++; $display("[TB] FAIL stall_bubble2_upd got=%0b exp=0", UpdValid); end
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h3A8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (UpdValid !== 1'b1) begin errors++; $display("[TB] FAIL stall_updvalid got=%0b exp=1", UpdValid); end
    checks++; if (UpdIdx !== 6'h31) begin errors++; $display("[TB] FAIL stall_updidx got=%0h exp=31", UpdIdx); end
    checks++; if (UpdTaken !== 1'b1) begin errors++; $display("[TB] FAIL stall_updtaken got=%0b exp=1", UpdTaken); end
    nextCycle();
  endtask

  // Reset asserted during RECOVER; the block must come back idle and usable.
  task automatic test_reset_recover();
    applyStimulus(1'b0, 32'h0, 32'h108, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h10C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h180, 32'h10C);
    @(negedge clk);
    checks++; if (Redirect !== 1'b1) begin errors++; $display("[TB] FAIL rr_redirect got=%0b exp=1", Redirect); end
    nextCycle();
    reset = 1'b0;
    applyStimulus(1'b1, 32'h40, 32'h180, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h184, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h55, 32'h58);
    @(negedge clk);
    checks++; if (Redirect !== 1'b0) begin errors++; $display("[TB] FAIL rr_post_redirect got=%0b exp=0", Redirect); end
    checks++; if (UpdValid !== 1'b0) begin errors++; $display("[TB] FAIL rr_post_updvalid got=%0b exp=0", UpdValid); end
    checks++; if (UpdIdx !== 6'h00) begin errors++; $display("[TB] FAIL rr_post_updidx got=%0h exp=0", UpdIdx); end
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h188, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h55, 32'h58);
    @(negedge clk);
    checks++; if (UpdValid !== 1'b0) begin errors++; $display("[TB] FAIL rr_empty_e_upd got=%0b exp=0", UpdValid); end
    nextCycle();
    applyStimulus(1'b0, 32'h0, 32'h18C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1C0, 32'h188);
    @(negedge clk);
    checks++; if (Redirect !== 1'b1) begin errors++; $display("[TB] FAIL rr_idle_redirect got=%0b exp=1", Redirect); end
    checks++; if (RedirectPC !== 32'h1C0) begin errors++; $display("[TB] FAIL rr_idle_redirectpc got=%0h exp=1c0", RedirectPC); end
    nextCycle();
  endtask

  typedef struct packed {
    logic        v;
    logic        bp;
    logic [31:0] tgt;
    logic [31:0] pc;
  } slot_t;

  // Randomized run. The model tracks which fetched instruction sits in D and
  // in E, and decides redirects from the prediction/outcome rules directly.
  task automatic test_random();
    slot_t            mD;
    slot_t            mE;
    bit               mRecover;
    bit               expUpdV;
    logic [IDX_W-1:0] expUpdIdx;
    bit               expUpdTk;
    bit               expRed;
    logic [31:0]      expPC;
    logic             bpf, stall, fd, fe, br, tk;
    logic [31:0]      tgtf, pcf, ptgt, pp4;
`ifdef BRU_PERF_CNT_EN
    logic [31:0]      mBranchCnt;
    logic [31:0]      mMissCnt;
    mBranchCnt = 32'h0;
    mMissCnt   = 32'h0;
`endif
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    reset     = 1'b1;
    mD        = '0;
    mE        = '0;
    mRecover  = 1'b0;
    expUpdV   = 1'b0;
    expUpdIdx = '0;
    expUpdTk  = 1'b0;
    for (int n = 0; n < 400; n++) begin
      bpf   = 1'($urandom_range(0, 1));
      tgtf  = {$urandom_range(0, 255), 2'b00};
      pcf   = {$urandom_range(0, 1023), 2'b00};
      stall = ($urandom_range(0, 9) < 2);
      fd    = ($urandom_range(0, 9) == 0);
      fe    = ($urandom_range(0, 9) == 0);
      br    = ($urandom_range(0, 9) < 7);
      tk    = 1'($urandom_range(0, 1));
      ptgt  = ($urandom_range(0, 1) == 1) ? mE.tgt : {$urandom_range(0, 255), 2'b00};
      pp4   = {$urandom_range(0, 1023), 2'b00};
      expRed = mE.v && br && !mRecover &&
               ((mE.bp != tk) || (mE.bp && tk && (mE.tgt != ptgt)));
      expPC  = tk ? ptgt : pp4;
      applyStimulus(bpf, tgtf, pcf, stall, fd, fe, br, tk, ptgt, pp4);
      @(negedge clk);
      checks++; if (Redirect !== expRed) begin errors++; $display("[TB] FAIL rnd_redirect cycle=%0d got=%0b exp=%0b", n, Redirect, expRed); end
      checks++; if (FlushReqD !== expRed) begin errors++; $display("[TB] FAIL rnd_flushd cycle=%0d got=%0b exp=%0b", n, FlushReqD, expRed); end
      checks++; if (FlushReqE !== expRed) begin errors++; $display("[TB] FAIL rnd_flushe cycle=%0d got=%0b exp=%0b", n, FlushReqE, expRed); end
      if (expRed) begin
        checks++; if (RedirectPC !== expPC) begin errors++; $display("[TB] FAIL rnd_redirectpc cycle=%0d got=%0h exp=%0h", n, RedirectPC, expPC); end
      end
      checks++; if (UpdValid !== expUpdV) begin errors++; $display("[TB] FAIL rnd_updvalid cycle=%0d got=%0b exp=%0b", n, UpdValid, expUpdV); end
      if (expUpdV) begin
        checks++; if (UpdIdx !== expUpdIdx) begin errors++; $display("[TB] FAIL rnd_updidx cycle=%0d got=%0h exp=%0h", n, UpdIdx, expUpdIdx); end
        checks++; if (UpdTaken !== expUpdTk) begin errors++; $display("[TB] FAIL rnd_updtaken cycle=%0d got=%0b exp=%0b", n, UpdTaken, expUpdTk); end
      end
`ifdef BRU_PERF_CNT_EN
      checks++; if (BranchCnt !== mBranchCnt) begin errors++; $display("[TB] FAIL rnd_branchcnt cycle=%0d got=%0d exp=%0d", n, BranchCnt, mBranchCnt); end
      checks++; if (MissCnt !== mMissCnt) begin errors++; $display("[TB] FAIL rnd_misscnt cycle=%0d got=%0d exp=%0d", n, MissCnt, mMissCnt); end
      if (expUpdV && (mBranchCnt != 32'hFFFF_FFFF)) mBranchCnt = mBranchCnt + 32'd1;
      if (expRed && (mMissCnt != 32'hFFFF_FFFF)) mMissCnt = mMissCnt + 32'd1;
`endif
      expUpdV = mE.v && br;
      if (expUpdV) begin
        expUpdIdx = mE.pc[IDX_W+1:2];
        expUpdTk  = tk;
      end
      mRecover = expRed;
      mE = (fe || expRed || stall) ? slot_t'('0) : mD;
      if (fd || expRed) mD = '0;
      else if (!stall) mD = '{v: 1'b1, bp: bpf, tgt: tgtf, pc: pcf};
      nextCycle();
    end
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    $display("[TB] starting branch_resolve_unit bench");
    test_reset();
    test_correct_not_taken();
    test_mispredict_taken();
    test_mispredict_not_taken();
    test_stall();
    test_reset_recover();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
